// File: rtl/main_mem_responder_if.sv
// Cache refill/writeback bus between the M-stage data cache (master) and main memory (slave).
interface main_mem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic        wvalid_i;
    logic [31:0] wdata_i;
    logic        wready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        rlast_o;
    logic        wdone_o;
    logic        err_o;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, wvalid_i, wdata_i,
        output req_ready_o, wready_o, rvalid_o, rdata_o, rlast_o, wdone_o, err_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, wvalid_i, wdata_i,
        input  req_ready_o, wready_o, rvalid_o, rdata_o, rlast_o, wdone_o, err_o
    );
endinterface

// File: rtl/main_mem_responder.sv
// Line-granular main-memory responder: fixed latency, then BURST_LEN read or write beats.
// Define MAIN_MEM_OOR_ERR_EN to flag (and neutralise) requests with address bits above ADDR_WIDTH.
module main_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned LATENCY    = 8
) (
    input  logic                clk,
    input  logic                rst,
    main_mem_responder_if.slave bus
);
    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned LINE_W = WIDX_W - BEAT_W;
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned DEPTH  = 1 << WIDX_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RBURST,
        S_WBURST,
        S_WDONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [LAT_W-1:0]    w_lat_cnt_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_cnt_nxt;
    logic [LINE_W-1:0]   r_line;
    logic [LINE_W-1:0]   w_line_nxt;
    logic                r_write;
    logic                w_write_nxt;
    logic                r_oor;
    logic                w_oor_nxt;

    logic                r_req_ready;
    logic                r_wready;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic                r_rlast;
    logic                r_wdone;
    logic                r_err;

    logic                w_req_ready_nxt;
    logic                w_wready_nxt;
    logic                w_rvalid_nxt;
    logic                w_rlast_nxt;
    logic                w_wdone_nxt;
    logic                w_err_nxt;
    logic [WIDX_W-1:0]   w_rd_idx;

    logic                w_accept;
    logic                w_wbeat;
    logic                w_req_oor;
    logic                w_wr_en;
    logic [WIDX_W-1:0]   w_wr_idx;
    logic                w_unused_addr;

    logic [31:0]         r_mem [DEPTH];

    assign w_accept      = bus.req_valid_i & r_req_ready;
    assign w_wbeat       = bus.wvalid_i & r_wready;
    assign w_unused_addr = ^bus.req_addr_i;

`ifdef MAIN_MEM_OOR_ERR_EN
    assign w_req_oor = |(bus.req_addr_i >> ADDR_WIDTH);
`else
    assign w_req_oor = 1'b0;
`endif

    // State and outputs are registered from the same next-state values, so every
    // output reflects the state it describes with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_line      <= '0;
            r_write     <= 1'b0;
            r_oor       <= 1'b0;
            r_req_ready <= 1'b1;
            r_wready    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rlast     <= 1'b0;
            r_wdone     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_line      <= w_line_nxt;
            r_write     <= w_write_nxt;
            r_oor       <= w_oor_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_wready    <= w_wready_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_rdata     <= (w_rvalid_nxt && !w_oor_nxt) ? r_mem[w_rd_idx] : '0;
            r_rlast     <= w_rlast_nxt;
            r_wdone     <= w_wdone_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lat_cnt_nxt  = r_lat_cnt;
        w_beat_cnt_nxt = r_beat_cnt;
        w_line_nxt     = r_line;
        w_write_nxt    = r_write;
        w_oor_nxt      = r_oor;
        unique case (r_state)
            S_IDLE: begin
                w_oor_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt    = S_WAIT;
                    w_lat_cnt_nxt  = LAT_INIT;
                    w_beat_cnt_nxt = '0;
                    w_line_nxt     = bus.req_addr_i[ADDR_WIDTH-1:BEAT_W+2];
                    w_write_nxt    = bus.req_write_i;
                    w_oor_nxt      = w_req_oor;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt    = r_write ? S_WBURST : S_RBURST;
                    w_beat_cnt_nxt = '0;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                end
            end
            S_RBURST: begin
                if (r_beat_cnt == LAST_BEAT) begin
                    w_state_nxt    = S_IDLE;
                    w_beat_cnt_nxt = '0;
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                end
            end
            S_WBURST: begin
                if (w_wbeat) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt    = S_WDONE;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                    end
                end
            end
            S_WDONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_wready_nxt    = (w_state_nxt == S_WBURST);
        w_rvalid_nxt    = (w_state_nxt == S_RBURST);
        w_rlast_nxt     = (w_state_nxt == S_RBURST) && (w_beat_cnt_nxt == LAST_BEAT);
        w_wdone_nxt     = (w_state_nxt == S_WDONE);
        w_err_nxt       = (w_state_nxt != S_IDLE) && w_oor_nxt;
        w_rd_idx        = {w_line_nxt, w_beat_cnt_nxt};
    end

    // Beats landing on the reset edge are dropped; earlier beats stay committed.
    assign w_wr_en  = w_wbeat && !r_oor && !rst;
    assign w_wr_idx = {r_line, r_beat_cnt};

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.wdata_i;
        end
    end

    assign bus.req_ready_o = r_req_ready;
    assign bus.wready_o    = r_wready;
    assign bus.rvalid_o    = r_rvalid;
    assign bus.rdata_o     = r_rdata;
    assign bus.rlast_o     = r_rlast;
    assign bus.wdone_o     = r_wdone;
    assign bus.err_o       = r_err;

endmodule
